histogram_ctrl: RTL and testbench

- Frame sequencer that sits downstream of the histogram datapath. It consumes the stream of bin indices (data/valid/sof) and accumulates one counter per bin over a fixed-length frame.
- At end of frame it dumps all bin counts as an output stream with a valid/busy handshake, clearing each bin as it is read, then re-arms for the next frame.
- Provides backpressure upstream via busy_out while dumping.

---
 rtl/histogram_pkg.sv | 25 ++
 rtl/histogram_ctrl_hist_bin_bank.sv | 68 ++++++
 rtl/histogram_ctrl.sv | 146 ++++++++++++++
 tb/tb_histogram_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/histogram_pkg.sv
// histogram_pkg: shared types and sizing for the histogram frame sequencer.
//   state_e      - sequencer states (IDLE, ACCUM, DUMP)
//   BIN_IDX_W    - width of a bin index on data_in / bin_out
//   PIX_CNT_W    - pixel-count width for the default 1024-sample frame
//   pix_cnt_w()  - pixel-count width for an arbitrary frame length
package histogram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DUMP  = 2'd2
  } state_e;

  localparam int unsigned BIN_IDX_W        = 8;
  localparam int unsigned FRAME_PIXELS_DEF = 1024;
  localparam int unsigned PIX_CNT_W        = $clog2(FRAME_PIXELS_DEF + 1);

  typedef logic [BIN_IDX_W-1:0] bin_idx_t;

  // Wide enough to hold the frame length itself, not just length-1.
  function automatic int unsigned pix_cnt_w(input int unsigned frame_pixels);
    return $clog2(frame_pixels + 1);
  endfunction

endpackage

// File: rtl/histogram_ctrl_hist_bin_bank.sv
// hist_bin_bank: one counter per bin.
//   Macro HISTOGRAM_CTRL_SATURATE_EN: when defined, counters stick at all-ones
//   instead of wrapping.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset (clears all bins)
//   inc_en/inc_idx  increment bin inc_idx; indices >= p_bins are ignored
//   rd_idx/rd_cnt   combinational read; rd_cnt already includes an increment
//                   landing on rd_idx this cycle; out-of-range reads give 0
//   clr_en/clr_idx  clear bin clr_idx (clear-on-read from the dump sequencer)
module hist_bin_bank
  import histogram_pkg::*;
#(
  parameter int p_bins       = 30,
  parameter int p_count_bits = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    inc_en,
  input  logic [BIN_IDX_W-1:0]    inc_idx,
  input  logic [BIN_IDX_W-1:0]    rd_idx,
  output logic [p_count_bits-1:0] rd_cnt,
  input  logic                    clr_en,
  input  logic [BIN_IDX_W-1:0]    clr_idx
);

  typedef logic [p_count_bits-1:0] cnt_t;

  localparam bin_idx_t NBINS = bin_idx_t'(p_bins);

  cnt_t cnt_q [p_bins];
  cnt_t rd_cur;
  logic inc_hit;

  function automatic cnt_t bump(input cnt_t v);
`ifdef HISTOGRAM_CTRL_SATURATE_EN
    return (&v) ? v : v + cnt_t'(1);
`else
    return v + cnt_t'(1);
`endif
  endfunction

  assign inc_hit = inc_en && (inc_idx < NBINS);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < p_bins; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < p_bins; i++) begin
        if (clr_en && (clr_idx == bin_idx_t'(i)))
          cnt_q[i] <= '0;
        else if (inc_hit && (inc_idx == bin_idx_t'(i)))
          cnt_q[i] <= bump(cnt_q[i]);
      end
    end
  end

  always_comb begin
    rd_cur = '0;
    for (int i = 0; i < p_bins; i++) begin
      if (rd_idx == bin_idx_t'(i)) rd_cur = cnt_q[i];
    end
  end

  // Forwarding lets the dump start with bin 0's count on the same edge that
  // accepts the last frame sample.
  assign rd_cnt = (inc_hit && (inc_idx == rd_idx)) ? bump(rd_cur) : rd_cur;

endmodule

// File: rtl/histogram_ctrl.sv
// histogram_ctrl: frame sequencer behind the histogram datapath.
// Accumulates one counter per bin over p_frame_pixels samples (sof sample
// included), then streams every bin out with clear-on-read and re-arms.
//   Macro HISTOGRAM_CTRL_SATURATE_EN: saturating bin counters (default wraps).
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   data_in/valid_in/sof_in   upstream bin-index stream
//   busy_out                  registered upstream stall, high for the whole dump
//   bin_out/count_out         dumped bin and its count
//   valid_out/sof_out/last_out  dump beat qualifiers (bin 0 / bin p_bins-1)
//   sof_err                   one-cycle pulse for a sof seen mid-frame
//   busy_in                   downstream stall; holds all outputs
module histogram_ctrl
  import histogram_pkg::*;
#(
  parameter int p_bins         = 30,
  parameter int p_frame_pixels = 1024,
  parameter int p_count_bits   = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [7:0]              data_in,
  input  logic                    valid_in,
  input  logic                    sof_in,
  output logic                    busy_out,
  output logic [7:0]              bin_out,
  output logic [p_count_bits-1:0] count_out,
  output logic                    valid_out,
  output logic                    sof_out,
  output logic                    last_out,
  output logic                    sof_err,
  input  logic                    busy_in
);

  localparam int PW = pix_cnt_w(p_frame_pixels);
  typedef logic [PW-1:0] pix_t;

  localparam pix_t     LAST_PIX = pix_t'(p_frame_pixels);
  localparam bin_idx_t LAST_BIN = bin_idx_t'(p_bins - 1);

  state_e                  state_q;
  pix_t                    pix_cnt_q;
  pix_t                    pix_nxt;
  logic                    inc_en;
  logic                    clr_en;
  logic                    frame_done;
  bin_idx_t                rd_idx;
  bin_idx_t                bin_nxt;
  logic [p_count_bits-1:0] rd_cnt;

  // pix_cnt_q is 0 in IDLE, so the same "+1" covers the sof sample.
  assign pix_nxt    = pix_cnt_q + pix_t'(1);
  assign frame_done = (pix_nxt == LAST_PIX);
  assign bin_nxt    = bin_out + bin_idx_t'(1);

  always_comb begin
    inc_en = valid_in && (((state_q == IDLE) && sof_in) ||
                          ((state_q == ACCUM) && !sof_in));
    clr_en = valid_out && !busy_in;
    // Outside a dump, look at bin 0 so the first beat can load on entry.
    rd_idx = (state_q == DUMP) ? bin_nxt : '0;
  end

  hist_bin_bank #(
    .p_bins       (p_bins),
    .p_count_bits (p_count_bits)
  ) u_bank (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .inc_en  (inc_en),
    .inc_idx (data_in),
    .rd_idx  (rd_idx),
    .rd_cnt  (rd_cnt),
    .clr_en  (clr_en),
    .clr_idx (bin_out)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      pix_cnt_q <= '0;
      busy_out  <= 1'b0;
      valid_out <= 1'b0;
      sof_out   <= 1'b0;
      last_out  <= 1'b0;
      sof_err   <= 1'b0;
      bin_out   <= '0;
      count_out <= '0;
    end else begin
      sof_err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (inc_en) begin
            pix_cnt_q <= pix_nxt;
            if (frame_done) begin
              state_q   <= DUMP;
              busy_out  <= 1'b1;
              valid_out <= 1'b1;
              sof_out   <= 1'b1;
              last_out  <= 1'b0;
              bin_out   <= '0;
              count_out <= rd_cnt;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (valid_in && sof_in) begin
            sof_err <= 1'b1;
          end else if (inc_en) begin
            pix_cnt_q <= pix_nxt;
            if (frame_done) begin
              state_q   <= DUMP;
              busy_out  <= 1'b1;
              valid_out <= 1'b1;
              sof_out   <= 1'b1;
              last_out  <= 1'b0;
              bin_out   <= '0;
              count_out <= rd_cnt;
            end
          end
        end
        DUMP: begin
          if (valid_out && !busy_in) begin
            if (bin_out == LAST_BIN) begin
              state_q   <= IDLE;
              pix_cnt_q <= '0;
              busy_out  <= 1'b0;
              valid_out <= 1'b0;
              sof_out   <= 1'b0;
              last_out  <= 1'b0;
            end else begin
              bin_out   <= bin_nxt;
              count_out <= rd_cnt;
              sof_out   <= 1'b0;
              last_out  <= (bin_nxt == LAST_BIN);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_histogram_ctrl.sv
module tb_histogram_ctrl;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  logic i_rst_n;

  // Instance A: 30 bins, 8-sample frames, 16-bit counts
  logic [7:0]  data_a;
  logic        valid_a, sof_a, busy_in_a;
  logic        busy_out_a, valid_out_a, sof_out_a, last_out_a, sof_err_a;
  logic [7:0]  bin_out_a;
  logic [15:0] count_out_a;

  // Instance B: 4 bins, 10-sample frames, 3-bit counts
  logic [7:0]  data_b;
  logic        valid_b, sof_b, busy_in_b;
  logic        busy_out_b, valid_out_b, sof_out_b, last_out_b, sof_err_b;
  logic [7:0]  bin_out_b;
  logic [2:0]  count_out_b;

  histogram_ctrl #(.p_bins(30), .p_frame_pixels(8), .p_count_bits(16)) dut_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .data_in(data_a), .valid_in(valid_a),
    .sof_in(sof_a), .busy_out(busy_out_a), .bin_out(bin_out_a),
    .count_out(count_out_a), .valid_out(valid_out_a), .sof_out(sof_out_a),
    .last_out(last_out_a), .sof_err(sof_err_a), .busy_in(busy_in_a));

  histogram_ctrl #(.p_bins(4), .p_frame_pixels(10), .p_count_bits(3)) dut_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .data_in(data_b), .valid_in(valid_b),
    .sof_in(sof_b), .busy_out(busy_out_b), .bin_out(bin_out_b),
    .count_out(count_out_b), .valid_out(valid_out_b), .sof_out(sof_out_b),
    .last_out(last_out_b), .sof_err(sof_err_b), .busy_in(busy_in_b));

  typedef struct packed {
    logic [7:0]  bin;
    logic [15:0] cnt;
    logic        sof;
    logic        last;
  } beat_t;

  beat_t q_a[$];
  beat_t q_b[$];
  int    exp_a[30];
  int    nchecks = 0;
  int    nerrors = 0;
  int    run_a = 0, dump_len_a = 0, sof_err_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: compare every presented beat (stalled ones too,
  // which proves the hold), pop only when the beat is accepted.
  always @(negedge i_clk) begin
    if (i_rst_n && valid_out_a) begin
      check("busy_out_a in dump", busy_out_a, 1);
      if (q_a.size() == 0) begin
        nchecks++; nerrors++;
        $display("FAIL dump_a unexpected beat bin=%0d cnt=%0d", bin_out_a, count_out_a);
      end else begin
        check($sformatf("dump_a beat %0d", q_a[0].bin),
              {bin_out_a, count_out_a, sof_out_a, last_out_a}, q_a[0]);
        if (!busy_in_a) void'(q_a.pop_front());
      end
    end
  end

  always @(negedge i_clk) begin
    if (i_rst_n && valid_out_b) begin
      if (q_b.size() == 0) begin
        nchecks++; nerrors++;
        $display("FAIL dump_b unexpected beat bin=%0d cnt=%0d", bin_out_b, count_out_b);
      end else begin
        check($sformatf("dump_b beat %0d", q_b[0].bin),
              {bin_out_b, 13'd0, count_out_b, sof_out_b, last_out_b}, q_b[0]);
        if (!busy_in_b) void'(q_b.pop_front());
      end
    end
  end

  always @(negedge i_clk) begin
    if (valid_out_a) run_a++;
    else if (run_a > 0) begin dump_len_a = run_a; run_a = 0; end
    if (sof_err_a) sof_err_cnt++;
  end

  task automatic clear_exp();
    for (int i = 0; i < 30; i++) exp_a[i] = 0;
  endtask

  task automatic push_a();
    for (int i = 0; i < 30; i++)
      q_a.push_back('{bin: 8'(i), cnt: 16'(exp_a[i]), sof: (i == 0), last: (i == 29)});
  endtask

  task automatic drive_a(input int d, input logic s);
    data_a = 8'(d); sof_a = s; valid_a = 1'b1;
    @(posedge i_clk); #1;
    valid_a = 1'b0; sof_a = 1'b0;
  endtask

  task automatic drive_b(input int d, input logic s);
    data_b = 8'(d); sof_b = s; valid_b = 1'b1;
    @(posedge i_clk); #1;
    valid_b = 1'b0; sof_b = 1'b0;
  endtask

  task automatic first_beat(input string name);
    check({name, " first beat"}, {valid_out_a, busy_out_a, sof_out_a, bin_out_a}, {3'b111, 8'd0});
  endtask

  task automatic wait_dump_a(input int exp_len, input string name);
    int n;
    n = 0;
    while ((q_a.size() != 0 || valid_out_a) && n < 200) begin
      @(negedge i_clk); n++;
    end
    if (n >= 200) begin
      nchecks++; nerrors++;
      $display("FAIL %s timeout: %0d beats left, required 0", name, q_a.size());
    end
    @(posedge i_clk); #1;
    check({name, " length"}, dump_len_a, exp_len);
    check({name, " busy released"}, busy_out_a, 0);
  endtask

  task automatic wait_bin_a(input int b);
    int n;
    n = 0;
    while (!(valid_out_a && bin_out_a == 8'(b)) && n < 60) begin
      @(posedge i_clk); #1; n++;
    end
    check($sformatf("reached bin %0d", b), {valid_out_a, bin_out_a}, {1'b1, 8'(b)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int errs_before;
    int n;
    i_rst_n = 1'b0;
    data_a = '0; valid_a = 1'b0; sof_a = 1'b0; busy_in_a = 1'b0;
    data_b = '0; valid_b = 1'b0; sof_b = 1'b0; busy_in_b = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset ctrl", {busy_out_a, valid_out_a, sof_out_a, last_out_a, sof_err_a}, 0);
    check("reset data", {bin_out_a, count_out_a}, 0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Frame 1: basic accumulation, out-of-range index 40 counted but dropped
    clear_exp();
    exp_a[0] = 1; exp_a[1] = 2; exp_a[5] = 1; exp_a[29] = 3;
    push_a();
    drive_a(0, 1); drive_a(1, 0); drive_a(1, 0); drive_a(29, 0);
    drive_a(29, 0); drive_a(29, 0); drive_a(5, 0);
    check("no early dump", {valid_out_a, busy_out_a}, 0);
    drive_a(40, 0);
    first_beat("frame1");
    wait_dump_a(30, "frame1 dump");

    // Frame 2: 3-cycle stall at bin 4, with junk valid_in during the dump
    clear_exp();
    exp_a[4] = 5; exp_a[0] = 1; exp_a[10] = 2;
    push_a();
    drive_a(4, 1); drive_a(4, 0); drive_a(4, 0); drive_a(4, 0);
    drive_a(4, 0); drive_a(0, 0); drive_a(10, 0); drive_a(10, 0);
    first_beat("frame2");
    wait_bin_a(4);
    busy_in_a = 1'b1;
    data_a = 8'd0; valid_a = 1'b1; sof_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge i_clk); #1;
      check($sformatf("stall hold %0d", k), {busy_out_a, valid_out_a, bin_out_a, count_out_a},
            {2'b11, 8'd4, 16'd5});
    end
    busy_in_a = 1'b0; valid_a = 1'b0;
    wait_dump_a(33, "frame2 dump");

    // Frame 3: idle samples without sof ignored; counts from this frame only
    drive_a(3, 0); drive_a(3, 0);
    check("idle discard", {busy_out_a, valid_out_a}, 0);
    clear_exp();
    exp_a[2] = 2; exp_a[3] = 3; exp_a[0] = 1; exp_a[29] = 1; exp_a[10] = 1;
    push_a();
    drive_a(2, 1); drive_a(2, 0); drive_a(3, 0); drive_a(3, 0);
    drive_a(3, 0); drive_a(0, 0); drive_a(29, 0); drive_a(10, 0);
    first_beat("frame3");
    wait_dump_a(30, "frame3 dump");

    // Frame 4: sof mid-frame at sample 3 is dropped and flagged once
    errs_before = sof_err_cnt;
    clear_exp();
    exp_a[7] = 1; exp_a[8] = 3; exp_a[1] = 3; exp_a[2] = 1;
    push_a();
    drive_a(7, 1); drive_a(8, 0); drive_a(9, 1);
    check("sof_err pulse", sof_err_a, 1);
    drive_a(8, 0);
    check("sof_err one cycle", sof_err_a, 0);
    drive_a(8, 0); drive_a(1, 0); drive_a(1, 0); drive_a(1, 0);
    check("no dump before 8 counted", valid_out_a, 0);
    drive_a(2, 0);
    first_beat("frame4");
    check("sof_err count", sof_err_cnt - errs_before, 1);
    wait_dump_a(30, "frame4 dump");

    // Frame 5: asynchronous reset in the middle of the dump
    clear_exp();
    exp_a[10] = 4; exp_a[11] = 4;
    push_a();
    drive_a(10, 1); drive_a(10, 0); drive_a(10, 0); drive_a(10, 0);
    drive_a(11, 0); drive_a(11, 0); drive_a(11, 0); drive_a(11, 0);
    wait_bin_a(10);
    #2 i_rst_n = 1'b0;
    #1;
    check("async reset ctrl", {busy_out_a, valid_out_a, sof_out_a, last_out_a, sof_err_a}, 0);
    check("async reset data", {bin_out_a, count_out_a}, 0);
    q_a.delete();
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Frame 6: after the abort, nothing from frame 5 survives
    clear_exp();
    exp_a[10] = 1; exp_a[12] = 7;
    push_a();
    drive_a(10, 1);
    for (int k = 0; k < 7; k++) drive_a(12, 0);
    first_beat("frame6");
    wait_dump_a(30, "frame6 dump");

    // 3-bit counters, 10 hits on bin 2
    for (int i = 0; i < 4; i++) begin
`ifdef HISTOGRAM_CTRL_SATURATE_EN
      q_b.push_back('{bin: 8'(i), cnt: (i == 2) ? 16'd7 : 16'd0, sof: (i == 0), last: (i == 3)});
`else
      q_b.push_back('{bin: 8'(i), cnt: (i == 2) ? 16'd2 : 16'd0, sof: (i == 0), last: (i == 3)});
`endif
    end
    drive_b(2, 1);
    for (int k = 0; k < 9; k++) drive_b(2, 0);
    check("b first beat", {valid_out_b, busy_out_b, sof_out_b, bin_out_b}, {3'b111, 8'd0});
    n = 0;
    while ((q_b.size() != 0 || valid_out_b) && n < 50) begin
      @(negedge i_clk); n++;
    end
    check("b dump drained", q_b.size(), 0);
    check("b idle after dump", {valid_out_b, busy_out_b}, 0);

    @(posedge i_clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
